uc_secuenciador: RTL and testbench

- Sequencing control unit for the single-cycle 10-bit-PC microcontroller datapath.
- Decodes the 6-bit opcode into every datapath select and enable: PC source, relative and return selects, register write, immediate, I/O muxes, output-register enables and ALU op.
- Adds the sequential state the datapath lacks: a persistent zero flag, one-level call tracking, a HALT state machine and a valid/ack handshake per output port.

---
 rtl/uc_secuenciador_if.sv | 11 +
 rtl/uc_secuenciador.sv | 197 +++++++++++++++++++
 tb/tb_uc_secuenciador.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uc_secuenciador_if.sv
// Output-port handshake bundle for uc_secuenciador: one valid/ack pair per port.
// The sequencer drives out_valid (master); peripherals drive out_ack (slave).
interface uc_secuenciador_if #(
  parameter int unsigned NPORTS = 4
);
  logic [NPORTS-1:0] out_valid;
  logic [NPORTS-1:0] out_ack;

  modport master (output out_valid, input  out_ack);
  modport slave  (input  out_valid, output out_ack);
endinterface

// File: rtl/uc_secuenciador.sv
// Sequencing control unit for the single-cycle 10-bit-PC microcontroller datapath.
// Optional macro UC_RESUME_EN adds the run input, which lets a one-cycle pulse resume from HALT.
module uc_secuenciador #(
  parameter int unsigned NPORTS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               opcode,
  input  logic                     zero,
  input  logic [1:0]               puerto1,
  input  logic [1:0]               puerto2,
`ifdef UC_RESUME_EN
  input  logic                     run,
`endif
  uc_secuenciador_if.master        out_if,
  output logic                     s_inc,
  output logic                     s_inm,
  output logic                     s_rel,
  output logic                     s_ret,
  output logic                     we3,
  output logic                     selsalida,
  output logic                     selentrada,
  output logic                     enablebackup,
  output logic                     enable0,
  output logic                     enable1,
  output logic                     enable2,
  output logic                     enable3,
  output logic [2:0]               op,
  output logic                     halted,
  output logic                     call_active,
  output logic                     err_overrun,
  output logic                     err_call
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [2:0] GRP_LI   = 3'b000;
  localparam logic [2:0] GRP_J    = 3'b001;
  localparam logic [2:0] GRP_JZ   = 3'b010;
  localparam logic [2:0] GRP_JNZ  = 3'b011;
  localparam logic [2:0] GRP_JR   = 3'b100;
  localparam logic [2:0] GRP_CALL = 3'b101;
  localparam logic [2:0] GRP_SYS  = 3'b110;
  localparam logic [2:0] GRP_IO   = 3'b111;

  localparam logic [1:0] SYS_RET  = 2'b00;
  localparam logic [1:0] SYS_HALT = 2'b10;

  localparam logic [1:0] IO_OUTI  = 2'b00;
  localparam logic [1:0] IO_OUTR  = 2'b01;
  localparam logic [1:0] IO_IN    = 2'b10;
  localparam logic [1:0] IO_OUTP  = 2'b11;

  state_t            state_q, state_d;
  logic              zreg_q, zreg_d;
  logic              alu_prev_q, alu_prev_d;
  logic              call_active_q, call_active_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_call_q, err_call_d;
  logic [NPORTS-1:0] out_valid_q, out_valid_d;
  logic [NPORTS-1:0] en_c;
  logic              flag_z_c;

  // State and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      zreg_q        <= 1'b0;
      alu_prev_q    <= 1'b0;
      call_active_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_call_q    <= 1'b0;
      out_valid_q   <= '0;
    end else begin
      state_q       <= state_d;
      zreg_q        <= zreg_d;
      alu_prev_q    <= alu_prev_d;
      call_active_q <= call_active_d;
      err_overrun_q <= err_overrun_d;
      err_call_q    <= err_call_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Decode, next-state and status update; reset leaves every control at its default.
  always_comb begin
    state_d       = state_q;
    s_inc         = 1'b1;
    s_inm         = 1'b0;
    s_rel         = 1'b0;
    s_ret         = 1'b0;
    we3           = 1'b0;
    selsalida     = 1'b0;
    selentrada    = 1'b0;
    enablebackup  = 1'b0;
    en_c          = '0;
    op            = opcode[2:0];
    alu_prev_d    = 1'b0;
    flag_z_c      = alu_prev_q ? zero : zreg_q;
    zreg_d        = flag_z_c;
    call_active_d = call_active_q;
    err_call_d    = err_call_q;

    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (!opcode[3]) begin
            we3        = 1'b1;
            alu_prev_d = 1'b1;
          end else begin
            case (opcode[2:0])
              GRP_LI: begin
                we3   = 1'b1;
                s_inm = 1'b1;
              end
              GRP_J:   s_inc = 1'b0;
              GRP_JZ:  s_inc = !flag_z_c;
              GRP_JNZ: s_inc = flag_z_c;
              GRP_JR:  s_rel = 1'b1;
              GRP_CALL: begin
                s_inc         = 1'b0;
                enablebackup  = 1'b1;
                err_call_d    = err_call_q | call_active_q;
                call_active_d = 1'b1;
              end
              GRP_SYS: begin
                case (opcode[5:4])
                  SYS_RET: begin
                    // A RET without a pending call is dropped and flagged.
                    if (call_active_q) begin
                      s_ret         = 1'b1;
                      call_active_d = 1'b0;
                    end else begin
                      err_call_d = 1'b1;
                    end
                  end
                  SYS_HALT: begin
                    s_inc   = 1'b0;
                    state_d = ST_HALT;
                  end
                  default: ;
                endcase
              end
              GRP_IO: begin
                case (opcode[5:4])
                  IO_OUTI: en_c[puerto1] = 1'b1;
                  IO_OUTR: begin
                    en_c[puerto1] = 1'b1;
                    selsalida     = 1'b1;
                  end
                  IO_IN: begin
                    we3        = 1'b1;
                    selentrada = 1'b1;
                  end
                  IO_OUTP: begin
                    en_c[puerto2] = 1'b1;
                    selsalida     = 1'b1;
                  end
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
        ST_HALT: begin
          s_inc = 1'b0;
`ifdef UC_RESUME_EN
          if (run) begin
            s_inc   = 1'b1;
            state_d = ST_RUN;
          end
`endif
        end
        default: state_d = ST_RUN;
      endcase
    end

    // A new OUT wins over a same-cycle ack on the same port.
    err_overrun_d = err_overrun_q | (|(en_c & out_valid_q));
    out_valid_d   = en_c | (out_valid_q & ~out_if.out_ack);
  end

  assign enable0          = en_c[0];
  assign enable1          = en_c[1];
  assign enable2          = en_c[2];
  assign enable3          = en_c[3];
  assign out_if.out_valid = out_valid_q;
  assign halted           = (state_q == ST_HALT);
  assign call_active      = call_active_q;
  assign err_overrun      = err_overrun_q;
  assign err_call         = err_call_q;

endmodule

// File: tb/tb_uc_secuenciador.sv
// Scoreboard bench for uc_secuenciador: a spec-level model pushes expected controls and
// next-cycle status per driven cycle; they are popped and compared at the falling edge.
module tb_uc_secuenciador;

  localparam logic [5:0] ALU  = 6'b000010;
  localparam logic [5:0] LI   = 6'b011000;
  localparam logic [5:0] JZ   = 6'b001010;
  localparam logic [5:0] JNZ  = 6'b001011;
  localparam logic [5:0] JR   = 6'b001100;
  localparam logic [5:0] CALL = 6'b001101;
  localparam logic [5:0] RET  = 6'b001110;
  localparam logic [5:0] NOP  = 6'b011110;
  localparam logic [5:0] HALT = 6'b101110;
  localparam logic [5:0] OUTI = 6'b001111;
  localparam logic [5:0] OUTR = 6'b011111;
  localparam logic [5:0] INP  = 6'b101111;
  localparam logic [5:0] OUTP = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic [1:0] puerto1;
  logic [1:0] puerto2;
  logic       run;
  logic       s_inc, s_inm, s_rel, s_ret, we3, selsalida, selentrada, enablebackup;
  logic       enable0, enable1, enable2, enable3;
  logic [2:0] op;
  logic       halted, call_active, err_overrun, err_call;

  uc_secuenciador_if #(.NPORTS(4)) ifc ();

  uc_secuenciador #(.NPORTS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .zero         (zero),
    .puerto1      (puerto1),
    .puerto2      (puerto2),
`ifdef UC_RESUME_EN
    .run          (run),
`endif
    .out_if       (ifc),
    .s_inc        (s_inc),
    .s_inm        (s_inm),
    .s_rel        (s_rel),
    .s_ret        (s_ret),
    .we3          (we3),
    .selsalida    (selsalida),
    .selentrada   (selentrada),
    .enablebackup (enablebackup),
    .enable0      (enable0),
    .enable1      (enable1),
    .enable2      (enable2),
    .enable3      (enable3),
    .op           (op),
    .halted       (halted),
    .call_active  (call_active),
    .err_overrun  (err_overrun),
    .err_call     (err_call)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] ctrl;
    logic [7:0]  stat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state of the sequencer as the spec describes it.
  logic       m_zr, m_ap, m_call, m_halt, m_eo, m_ec;
  logic [3:0] m_valid;
  logic       stat_pending = 1'b0;
  logic [7:0] stat_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [5:0] opc, input logic [1:0] p1, input logic [1:0] p2,
                       input logic [3:0] ack, input logic z, input logic r, input logic rs,
                       output exp_t e);
    logic inc, inm, rel, ret, we, ss, se, eb, fz;
    logic [3:0] en;
    logic n_zr, n_ap, n_call, n_halt, n_eo, n_ec;
    logic [3:0] n_valid;
    inc = 1'b1; inm = 1'b0; rel = 1'b0; ret = 1'b0;
    we = 1'b0; ss = 1'b0; se = 1'b0; eb = 1'b0; en = 4'b0;
    fz = m_ap ? z : m_zr;
    n_zr = fz; n_ap = 1'b0; n_call = m_call; n_halt = m_halt; n_eo = m_eo; n_ec = m_ec;
    if (!rs) begin
      if (m_halt) begin
        inc = 1'b0;
`ifdef UC_RESUME_EN
        if (r) begin inc = 1'b1; n_halt = 1'b0; end
`endif
      end else begin
        casez (opc)
          6'b??0???: begin we = 1'b1; n_ap = 1'b1; end
          6'b??1000: begin we = 1'b1; inm = 1'b1; end
          6'b??1001: inc = 1'b0;
          6'b??1010: inc = !fz;
          6'b??1011: inc = fz;
          6'b??1100: rel = 1'b1;
          6'b??1101: begin inc = 1'b0; eb = 1'b1; if (m_call) n_ec = 1'b1; n_call = 1'b1; end
          6'b001110: if (m_call) begin ret = 1'b1; n_call = 1'b0; end else n_ec = 1'b1;
          6'b101110: begin inc = 1'b0; n_halt = 1'b1; end
          6'b001111: en[p1] = 1'b1;
          6'b011111: begin en[p1] = 1'b1; ss = 1'b1; end
          6'b101111: begin we = 1'b1; se = 1'b1; end
          6'b111111: begin en[p2] = 1'b1; ss = 1'b1; end
          default: ;
        endcase
      end
      if ((en & m_valid) != 4'b0) n_eo = 1'b1;
      n_valid = en | (m_valid & ~ack);
    end else begin
      n_zr = 1'b0; n_ap = 1'b0; n_call = 1'b0; n_halt = 1'b0; n_eo = 1'b0; n_ec = 1'b0;
      n_valid = 4'b0;
    end
    e.ctrl = {inc, inm, rel, ret, we, ss, se, eb, en, opc[2:0]};
    e.stat = {n_valid, n_halt, n_call, n_eo, n_ec};
    m_zr = n_zr; m_ap = n_ap; m_call = n_call; m_halt = n_halt;
    m_eo = n_eo; m_ec = n_ec; m_valid = n_valid;
  endtask

  task automatic cyc(input string tag, input logic [5:0] opc, input logic [1:0] p1,
                     input logic [1:0] p2, input logic [3:0] ack, input logic z,
                     input logic r, input logic rs);
    exp_t e;
    logic [14:0] ctrl_obs;
    logic [7:0]  stat_obs;
    opcode = opc; puerto1 = p1; puerto2 = p2; ifc.out_ack = ack;
    zero = z; run = r; reset = rs;
    model(opc, p1, p2, ack, z, r, rs, e);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    ctrl_obs = {s_inc, s_inm, s_rel, s_ret, we3, selsalida, selentrada, enablebackup,
                enable3, enable2, enable1, enable0, op};
    stat_obs = {ifc.out_valid, halted, call_active, err_overrun, err_call};
    check({tag, "/ctrl"}, 32'(ctrl_obs), 32'(e.ctrl));
    if (stat_pending) check({tag, "/stat"}, 32'(stat_obs), 32'(stat_exp));
    stat_exp     = e.stat;
    stat_pending = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = ALU; zero = 1'b0; puerto1 = 2'd0; puerto2 = 2'd0;
    run = 1'b0; ifc.out_ack = 4'b0;
    @(posedge clk);
    #1;

    cyc("rst0", ALU, 0, 0, 4'h0, 0, 0, 1);
    cyc("rst1", OUTI, 1, 0, 4'h0, 0, 0, 1);

    // Zero result held across two LIs; zero input toggled to prove the flag is stored.
    cyc("z_alu",  ALU, 0, 0, 4'h0, 0, 0, 0);
    cyc("z_li1",  LI,  0, 0, 4'h0, 1, 0, 0);
    cyc("z_li2",  LI,  0, 0, 4'h0, 0, 0, 0);
    cyc("z_jz",   JZ,  0, 0, 4'h0, 0, 0, 0);
    cyc("z_jnz",  JNZ, 0, 0, 4'h0, 0, 0, 0);
    cyc("nz_alu", ALU, 0, 0, 4'h0, 1, 0, 0);
    cyc("nz_li1", LI,  0, 0, 4'h0, 0, 0, 0);
    cyc("nz_li2", LI,  0, 0, 4'h0, 1, 0, 0);
    cyc("nz_jz",  JZ,  0, 0, 4'h0, 1, 0, 0);
    cyc("jr",     JR,  0, 0, 4'h0, 1, 0, 0);

    cyc("call",  CALL, 0, 0, 4'h0, 0, 0, 0);
    cyc("nop",   NOP,  0, 0, 4'h0, 0, 0, 0);
    cyc("ret",   RET,  0, 0, 4'h0, 0, 0, 0);
    cyc("ret2",  RET,  0, 0, 4'h0, 0, 0, 0);

    cyc("outi2", OUTI, 2, 0, 4'h0, 0, 0, 0);
    cyc("wait1", NOP,  0, 0, 4'h0, 0, 0, 0);
    cyc("wait2", NOP,  0, 0, 4'h0, 0, 0, 0);
    cyc("ack2",  NOP,  0, 0, 4'h4, 0, 0, 0);
    cyc("idle",  INP,  0, 0, 4'h0, 0, 0, 0);

    cyc("outr1a", OUTR, 1, 0, 4'h0, 0, 0, 0);
    cyc("outr1b", OUTR, 1, 0, 4'h0, 0, 0, 0);
    cyc("ack1",   NOP,  0, 0, 4'h2, 0, 0, 0);
    cyc("outp3",  OUTP, 0, 3, 4'h0, 0, 0, 0);
    cyc("race3",  OUTI, 3, 0, 4'h8, 0, 0, 0);
    cyc("ack3",   NOP,  0, 0, 4'h8, 0, 0, 0);
    cyc("call1",  CALL, 0, 0, 4'h0, 0, 0, 0);
    cyc("call2",  CALL, 0, 0, 4'h0, 0, 0, 0);
    cyc("ret3",   RET,  0, 0, 4'h0, 0, 0, 0);
    cyc("clr",    NOP,  0, 0, 4'h0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] ro;
      ro = 6'($urandom);
      if (ro == HALT) ro = NOP;
      cyc("rand", ro, 2'($urandom), 2'($urandom), 4'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(0, 23) == 0));
    end

    cyc("halt", HALT, 0, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("inhalt", 6'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 4'($urandom),
          1'($urandom), 0, 0);
    cyc("runpulse", HALT, 0, 0, 4'h0, 0, 1, 0);
    cyc("after",    ALU,  0, 0, 4'h0, 0, 0, 0);
    cyc("out0",     OUTI, 0, 0, 4'h0, 1, 0, 0);
    cyc("call4",    CALL, 0, 0, 4'h0, 0, 0, 0);
    cyc("halt2",    HALT, 0, 0, 4'h0, 0, 0, 0);
    cyc("inhalt2",  ALU,  0, 0, 4'h0, 0, 0, 0);
    cyc("rsthalt",  HALT, 0, 0, 4'h0, 0, 0, 1);
    cyc("post",     NOP,  0, 0, 4'h0, 0, 0, 0);
    cyc("tail",     NOP,  0, 0, 4'h0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
